// File: rtl/issue_pkg.sv
// Shared definitions for the dual-issue scheduler: entry layout, type codes,
// issue_enable encodings and a decoder that flattens an entry into hazard-relevant fields.
package issue_pkg;

    localparam int ENTRY_W = 107;
    localparam int NREG    = 32;

    localparam int DST_LSB   = 70;
    localparam int SRC0_LSB  = 65;
    localparam int SRC1_LSB  = 60;
    localparam int TYPE_LSB  = 24;
    localparam int MEAN_LSB  = 18;
    localparam int DVAL_LSB  = 12;
    localparam int EXE_LSB   = 2;
    localparam int DELOT_BIT = 1;
    localparam int VALID_BIT = 0;

    localparam logic [3:0] T_ALU    = 4'd0;
    localparam logic [3:0] T_BRANCH = 4'd1;
    localparam logic [3:0] T_LSU    = 4'd2;
    localparam logic [3:0] T_MDU    = 4'd3;

    localparam logic [5:0] MEANING_DIV = 6'h1a;

    localparam logic [1:0] IE_NONE = 2'b00;
    localparam logic [1:0] IE_ONE  = 2'b01;
    localparam logic [1:0] IE_TWO  = 2'b10;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_e;

    typedef struct packed {
        logic       valid;
        logic       delot;
        logic       is_br;
        logic       is_lsu;
        logic       is_mdu;
        logic       is_div;
        logic       exe_zero;
        logic       dst_wr;
        logic       src0_rd;
        logic       src1_rd;
        logic [4:0] dst;
        logic [4:0] src0;
        logic [4:0] src1;
    } dec_t;

    // r0 is folded out here so downstream hazard logic never sees it as used.
    function automatic dec_t decode(input logic [ENTRY_W-1:0] e);
        dec_t       d;
        logic [3:0] typ;
        typ        = e[TYPE_LSB +: 4];
        d.valid    = e[VALID_BIT];
        d.delot    = e[DELOT_BIT];
        d.is_br    = (typ == T_BRANCH);
        d.is_lsu   = (typ == T_LSU);
        d.is_mdu   = (typ == T_MDU);
        d.is_div   = (typ == T_MDU) && (e[MEAN_LSB +: 6] == MEANING_DIV);
        d.exe_zero = (e[EXE_LSB +: 5] == 5'd0);
        d.dst      = e[DST_LSB +: 5];
        d.src0     = e[SRC0_LSB +: 5];
        d.src1     = e[SRC1_LSB +: 5];
        d.dst_wr   = e[DVAL_LSB + 0] && (d.dst  != 5'd0);
        d.src0_rd  = e[DVAL_LSB + 1] && (d.src0 != 5'd0);
        d.src1_rd  = e[DVAL_LSB + 2] && (d.src1 != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Queue-head / writeback inputs and issue-packet outputs of the dual-issue scheduler.
interface issue_scheduler_if #(
    parameter int ENT_W = issue_pkg::ENTRY_W
);
    logic             flush;
    logic [ENT_W-1:0] q_inst0;
    logic [ENT_W-1:0] q_inst1;
    logic             ex_ready;
    logic [1:0]       wb_en;
    logic [4:0]       wb_dst0;
    logic [4:0]       wb_dst1;
    logic [1:0]       issue_enable;
    logic [ENT_W-1:0] iss_pkt0;
    logic [ENT_W-1:0] iss_pkt1;
    logic [1:0]       iss_valid;
    logic             div_busy;
    logic [31:0]      stall_cnt;

    modport master (
        output flush, q_inst0, q_inst1, ex_ready, wb_en, wb_dst0, wb_dst1,
        input  issue_enable, iss_pkt0, iss_pkt1, iss_valid, div_busy, stall_cnt
    );

    modport slave (
        input  flush, q_inst0, q_inst1, ex_ready, wb_en, wb_dst0, wb_dst1,
        output issue_enable, iss_pkt0, iss_pkt1, iss_valid, div_busy, stall_cnt
    );
endinterface

// File: rtl/issue_scoreboard.sv
// 32-entry register busy vector: two set ports (issue), two clear ports (writeback), six read ports.
module issue_scoreboard
    import issue_pkg::*;
(
    input  logic            clk,
    input  logic            rst_,
    input  logic            clr_all_i,
    input  logic [1:0]      set_en_i,
    input  logic [4:0]      set_idx0_i,
    input  logic [4:0]      set_idx1_i,
    input  logic [1:0]      clr_en_i,
    input  logic [4:0]      clr_idx0_i,
    input  logic [4:0]      clr_idx1_i,
    input  logic [5:0][4:0] rd_idx_i,
    output logic [5:0]      rd_busy_o
);
    logic [NREG-1:0] busy_q, busy_d;

    // Clears are applied before sets so a same-edge set on the written-back register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i[0]) busy_d[clr_idx0_i] = 1'b0;
        if (clr_en_i[1]) busy_d[clr_idx1_i] = 1'b0;
        if (set_en_i[0]) busy_d[set_idx0_i] = 1'b1;
        if (set_en_i[1]) busy_d[set_idx1_i] = 1'b1;
        busy_d[0] = 1'b0;
        if (clr_all_i) busy_d = '0;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    always_comb begin
        rd_busy_o = '0;
        for (int k = 0; k < 6; k++) rd_busy_o[k] = busy_q[rd_idx_i[k]];
    end

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: picks 0/1/2 queue-head entries per cycle, registers issue packets,
// tracks the divider and counts stall cycles.
//   state    | meaning
//   DIV_IDLE | divider free, MDU ops may issue
//   DIV_BUSY | divider running, cnt_q counts down to 0, MDU ops held
module issue_scheduler
    import issue_pkg::*;
#(
    parameter int DIV_LAT = 32,
    parameter int ENT_W   = ENTRY_W
) (
    input  logic            clk,
    input  logic            rst_,
    issue_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(DIV_LAT);

    dec_t             d0, d1;
    logic [5:0][4:0]  rd_idx;
    logic [5:0]       rd_busy;
    logic             sb_ok0, sb_ok1, pair_haz;
    logic             ok0, ok1, iss0, iss1;
    logic             div_go, div_busy;
    logic [1:0]       set_en;
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ENT_W-1:0] pkt0_q, pkt0_d, pkt1_q, pkt1_d;
    logic [1:0]       val_q, val_d;
    logic [31:0]      stall_q, stall_d;
    logic             unused_dec;

    assign d0         = decode(bus.q_inst0);
    assign d1         = decode(bus.q_inst1);
    assign unused_dec = d0.delot ^ d1.exe_zero;

    assign rd_idx = {d1.dst, d1.src1, d1.src0, d0.dst, d0.src1, d0.src0};
    assign sb_ok0 = !(d0.src0_rd && rd_busy[0]) && !(d0.src1_rd && rd_busy[1]) && !(d0.dst_wr && rd_busy[2]);
    assign sb_ok1 = !(d1.src0_rd && rd_busy[3]) && !(d1.src1_rd && rd_busy[4]) && !(d1.dst_wr && rd_busy[5]);

    assign pair_haz = d0.dst_wr && ((d1.src0_rd && d1.src0 == d0.dst) ||
                                    (d1.src1_rd && d1.src1 == d0.dst) ||
                                    (d1.dst_wr  && d1.dst  == d0.dst));

    assign ok0 = d0.valid && bus.ex_ready && !bus.flush && sb_ok0 && !(d0.is_mdu && div_busy);
    assign ok1 = ok0 && d1.valid && sb_ok1 && !(d1.is_mdu && div_busy) && !pair_haz &&
                 !(d0.is_lsu && d1.is_lsu) && !(d0.is_mdu && d1.is_mdu) &&
                 d0.exe_zero && !d1.is_br;

    // A branch in slot 0 never leaves without its delay slot.
    always_comb begin
        iss0 = ok0;
        iss1 = ok1;
        if (d0.is_br && (!d1.valid || (d1.delot && !ok1))) begin
            iss0 = 1'b0;
            iss1 = 1'b0;
        end
    end

    assign bus.issue_enable = iss1 ? IE_TWO : (iss0 ? IE_ONE : IE_NONE);

    assign set_en = {iss1 && d1.dst_wr, iss0 && d0.dst_wr};

    issue_scoreboard u_sb (
        .clk        (clk),
        .rst_       (rst_),
        .clr_all_i  (bus.flush),
        .set_en_i   (set_en),
        .set_idx0_i (d0.dst),
        .set_idx1_i (d1.dst),
        .clr_en_i   (bus.wb_en),
        .clr_idx0_i (bus.wb_dst0),
        .clr_idx1_i (bus.wb_dst1),
        .rd_idx_i   (rd_idx),
        .rd_busy_o  (rd_busy)
    );

    assign div_go   = (iss0 && d0.is_div) || (iss1 && d1.is_div);
    assign div_busy = (state_q == DIV_BUSY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DIV_IDLE: if (div_go) begin
                    state_d = DIV_BUSY;
                    cnt_d   = CNT_W'(DIV_LAT - 1);
                end
                DIV_BUSY: if (cnt_q == '0) state_d = DIV_IDLE;
                          else             cnt_d   = cnt_q - 1'b1;
                default: begin
                    state_d = DIV_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pkt0_d  = pkt0_q;
        pkt1_d  = pkt1_q;
        val_d   = val_q;
        stall_d = stall_q;
        if (bus.flush) begin
            val_d = '0;
        end else if (bus.ex_ready) begin
            val_d = {iss1, iss0};
            if (iss0) pkt0_d = bus.q_inst0;
            if (iss1) pkt1_d = bus.q_inst1;
        end
        if (d0.valid && !iss0 && !bus.flush && stall_q != '1) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            pkt0_q  <= '0;
            pkt1_q  <= '0;
            val_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pkt0_q  <= pkt0_d;
            pkt1_q  <= pkt1_d;
            val_q   <= val_d;
            stall_q <= stall_d;
        end
    end

    assign bus.iss_pkt0  = pkt0_q;
    assign bus.iss_pkt1  = pkt1_q;
    assign bus.iss_valid = val_q;
    assign bus.div_busy  = div_busy;
    assign bus.stall_cnt = stall_q;

endmodule
